// File: rtl/matmul_result_drain.sv
// rtl/matmul_result_drain.sv - snapshots the NxN accumulator array on done rise and streams it row-major
// Optional macro RESULT_SAT_EN selects signed saturation instead of wrap when narrowing to OUT_W.
module matmul_result_drain #(
  parameter int N     = 2,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   done,
  input  logic [N*N*ACC_W-1:0]   acc_flat,
  input  logic                   ovr_clr,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [OUT_W-1:0]       m_tdata,
  output logic                   m_tlast,
  output logic                   busy,
  output logic                   overrun
);

  localparam int NE    = N * N;
  localparam int IDX_W = (NE > 1) ? $clog2(NE) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NE - 1);

  logic [0:0]       state;
  logic [IDX_W-1:0] idx;
  logic             done_q;
  logic [ACC_W-1:0] snap [NE];

  logic             rise;
  logic             at_last;
  logic             hs;
  logic             final_hs;
  logic [ACC_W-1:0] cur;

  assign rise     = done & ~done_q;
  assign at_last  = (idx == LAST_IDX);
  assign m_tvalid = (state == SEND);
  assign m_tlast  = (state == SEND) & at_last;
  assign busy     = (state == SEND);
  assign hs       = m_tvalid & m_tready;
  assign final_hs = hs & at_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      done_q <= 1'b0;
      for (int e = 0; e < NE; e++) begin
        snap[e] <= '0;
      end
    end else begin
      done_q <= done;
      // A rise is only taken when idle or exactly as the last element leaves.
      if ((state == IDLE && rise) || (final_hs && rise)) begin
        state <= SEND;
        idx   <= '0;
        for (int e = 0; e < NE; e++) begin
          snap[e] <= acc_flat[e*ACC_W +: ACC_W];
        end
      end else if (final_hs) begin
        state <= IDLE;
      end else if (hs) begin
        idx <= idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (state == SEND && rise && !final_hs) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

  assign cur = snap[idx];

`ifdef RESULT_SAT_EN
  // The element fits when every bit from the OUT_W sign position upward agrees.
  logic [ACC_W-OUT_W:0] hi;
  assign hi = cur[ACC_W-1:OUT_W-1];

  always_comb begin
    m_tdata = cur[OUT_W-1:0];
    if (!((&hi) || (~|hi))) begin
      m_tdata = cur[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  logic unused_cur_bits;
  assign unused_cur_bits = ^cur;
  assign m_tdata = cur[OUT_W-1:0];
`endif

endmodule

// File: tb/tb_matmul_result_drain.sv
// tb/tb_matmul_result_drain.sv - randomized and directed self-checking bench for matmul_result_drain
// Reference is a queue of pending converted elements updated once per clock edge.
module tb_matmul_result_drain;

  localparam int N     = 2;
  localparam int ACC_W = 32;
  localparam int OUT_W = 16;
  localparam int NE    = N * N;

  logic                  clk;
  logic                  rst_n;
  logic                  done;
  logic [NE*ACC_W-1:0]   acc_flat;
  logic                  ovr_clr;
  logic                  m_tvalid;
  logic                  m_tready;
  logic [OUT_W-1:0]      m_tdata;
  logic                  m_tlast;
  logic                  busy;
  logic                  overrun;

  matmul_result_drain #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .done     (done),
    .acc_flat (acc_flat),
    .ovr_clr  (ovr_clr),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  int pend[$];
  bit m_ovr = 0;
  bit m_prev_done = 0;
  int got[$];

  task automatic chk(input string name, input int actual, input int want);
    checks++;
    if (actual != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, actual, want, $time);
    end
  endtask

  function automatic int conv(input int a);
    longint v;
    v = a;
`ifdef RESULT_SAT_EN
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
`else
    v = ((v % 65536) + 65536) % 65536;
    if (v >= 32768) v = v - 65536;
`endif
    return int'(v);
  endfunction

  // Reference: a set is a queue of converted elements; the head is what is on the bus.
  always @(posedge clk) begin
    bit was_busy, rise, hs;
    if (!rst_n) begin
      pend.delete();
      m_ovr = 0;
      m_prev_done = 0;
    end else begin
      was_busy = (pend.size() > 0);
      rise = done && !m_prev_done;
      hs = was_busy && m_tready;
      if (hs) void'(pend.pop_front());
      if (rise && (!was_busy || (hs && pend.size() == 0))) begin
        for (int e = 0; e < NE; e++) pend.push_back(conv($signed(acc_flat[e*ACC_W +: ACC_W])));
      end
      if (rise && was_busy && !(hs && pend.size() == 0 || (hs && pend.size() == NE)))
        m_ovr = 1;
      else if (ovr_clr)
        m_ovr = 0;
      m_prev_done = done;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tvalid", int'(m_tvalid), int'(pend.size() > 0));
      chk("busy", int'(busy), int'(pend.size() > 0));
      chk("overrun", int'(overrun), int'(m_ovr));
      if (pend.size() > 0) begin
        chk("tdata", int'($signed(m_tdata)), pend[0]);
        chk("tlast", int'(m_tlast), int'(pend.size() == 1));
      end else begin
        chk("tlast_idle", int'(m_tlast), 0);
      end
      if (m_tvalid && m_tready) got.push_back(int'($signed(m_tdata)));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_acc(input int a0, input int a1, input int a2, input int a3);
    acc_flat = {a3, a2, a1, a0};
  endtask

  task automatic check_got(input string name, input int w[$]);
    chk({name, "_count"}, got.size(), w.size());
    for (int i = 0; i < w.size() && i < got.size(); i++) chk(name, got[i], w[i]);
  endtask

  initial begin
    rst_n = 0; done = 0; ovr_clr = 0; m_tready = 0; acc_flat = '0;
    tick(1);
    chk_en = 1;
    tick(2);
    chk("rst_tvalid", int'(m_tvalid), 0);
    chk("rst_tlast", int'(m_tlast), 0);
    chk("rst_tdata", int'(m_tdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst_n = 1;
    tick(2);

    // Basic drain with one-cycle latency
    got.delete();
    set_acc(5, -3, 100, 7);
    m_tready = 1;
    done = 1;
    tick(1);
    chk("lat_tvalid", int'(m_tvalid), 1);
    chk("lat_tdata", int'($signed(m_tdata)), 5);
    done = 0;
    tick(6);
    check_got("basic", '{5, -3, 100, 7});
    chk("basic_busy_after", int'(busy), 0);

    // Backpressure
    got.delete();
    m_tready = 0;
    done = 1;
    tick(1);
    done = 0;
    for (int i = 0; i < 20; i++) begin
      m_tready = (i >= 3) && (i % 2 == 1);
      tick(1);
    end
    m_tready = 1;
    tick(2);
    check_got("bp", '{5, -3, 100, 7});

    // Conversion
    got.delete();
    set_acc(40000, -40000, 32767, -32768);
    done = 1;
    tick(1);
    done = 0;
    tick(6);
`ifdef RESULT_SAT_EN
    check_got("conv", '{32767, -32768, 32767, -32768});
`else
    check_got("conv", '{-25536, 25536, 32767, -32768});
`endif

    // Overrun while idx=1; snapshot must stay untouched
    got.delete();
    set_acc(11, 22, 33, 44);
    done = 1;
    tick(1);
    done = 0;
    tick(1);
    set_acc(9, 9, 9, 9);
    done = 1;
    tick(1);
    chk("ovr_set", int'(overrun), 1);
    done = 0;
    tick(4);
    check_got("ovr", '{11, 22, 33, 44});
    chk("ovr_sticky", int'(overrun), 1);
    ovr_clr = 1;
    tick(1);
    ovr_clr = 0;
    chk("ovr_clr", int'(overrun), 0);

    // Back-to-back: rise coincides with final handshake
    got.delete();
    set_acc(1, 2, 3, 4);
    done = 1;
    tick(1);
    done = 0;
    tick(3);
    chk("b2b_last", int'(m_tlast), 1);
    set_acc(-5, -6, -7, -8);
    done = 1;
    tick(1);
    chk("b2b_tvalid", int'(m_tvalid), 1);
    chk("b2b_tdata", int'($signed(m_tdata)), -5);
    done = 0;
    tick(5);
    check_got("b2b", '{1, 2, 3, 4, -5, -6, -7, -8});
    chk("b2b_overrun", int'(overrun), 0);

    // Reset mid-stream at idx=2 with overrun set
    got.delete();
    set_acc(100, 200, 300, 400);
    done = 1;
    tick(1);
    done = 0;
    tick(1);
    done = 1;
    tick(1);
    rst_n = 0;
    done = 0;
    tick(1);
    chk("mrst_tvalid", int'(m_tvalid), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_overrun", int'(overrun), 0);
    rst_n = 1;
    tick(2);
    got.delete();
    set_acc(-1, 0, 1, 2);
    done = 1;
    tick(1);
    done = 0;
    tick(6);
    check_got("fresh", '{-1, 0, 1, 2});

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int v[4];
      for (int k = 0; k < 4; k++)
        v[k] = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 80000)) - 40000;
      set_acc(v[0], v[1], v[2], v[3]);
      if ($urandom_range(0, 5) == 0) done = ~done;
      m_tready = ($urandom_range(0, 3) != 0);
      ovr_clr = ($urandom_range(0, 15) == 0);
      tick(1);
    end
    done = 0; ovr_clr = 0; m_tready = 1;
    tick(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matmul_result_drain.md
# matmul_result_drain

Output stage directly downstream of the matmul control/datapath pair. On the rising edge of the controller's `done`, it snapshots the full N×N accumulator array. It then streams the elements out one per handshake on an AXI-Stream-style master port, in row-major order, with `m_tlast` on the final element. It also flags `busy` so the top level can hold off the next `start` while a result set is still draining.

## Interface
- `N`, default 2: matrix dimension; N*N elements per result set.
- `ACC_W`, default 32: signed accumulator width per element.
- `OUT_W`, default 16: signed output element width; OUT_W ≤ ACC_W.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `done`  in  1: level from controller; high from end of FLUSH until `start` drops.
- `acc_flat`  in  N*N*ACC_W: accumulators; element e = row*N+col at `[e*ACC_W +: ACC_W]`, valid while `done`=1.
- `ovr_clr`  in  1: clears sticky `overrun`.
- `m_tvalid`  out  1: output element valid.
- `m_tready`  in  1: downstream ready.
- `m_tdata`  out  OUT_W: output element (signed).
- `m_tlast`  out  1: marks element N*N-1.
- `busy`  out  1: snapshot held, not fully drained.
- `overrun`  out  1: sticky; a `done` rise was dropped because the block was busy.

## Operation
- Rise detect: `done_q` is a registered copy of `done` (reset 0). `rise = done & ~done_q`.
- FSM states IDLE and SEND.
  - IDLE → SEND on `rise`: capture all of `acc_flat` into the snapshot register and set idx=0.
  - SEND: present element idx. On handshake (`m_tvalid & m_tready`) with idx < N*N-1, idx increments.
  - SEND, handshake at idx = N*N-1:
    - If `rise` occurs in the same cycle, recapture the snapshot, set idx=0 and stay in SEND (back-to-back, no bubble).
    - Otherwise go to IDLE.
- `rise` in SEND without a final handshake that cycle: snapshot and idx are untouched, and `overrun` is set to 1.
- `overrun` is cleared by `ovr_clr`. If set and clear occur in the same cycle, set wins.
- idx width is `$clog2(N*N)`, minimum 1 bit. idx never wraps past N*N-1.
- Output conversion from ACC_W to OUT_W is controlled by the Configuration macro.
- `m_tdata` is combinational from the snapshot register and idx, with no arithmetic on the path beyond conversion.

## Timing
- Reset values: state=IDLE, idx=0, `done_q`=0, snapshot=0, `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `busy`=0, `overrun`=0.
- Reset mid-stream aborts the transfer. `m_tvalid` is 0 in the cycle after the reset edge, and no partial set resumes.
- Latency: `done` high at edge T means capture at edge T, and `m_tvalid`=1 during cycle T+1 (one cycle).
- `m_tvalid = (state==SEND)`, `m_tlast = (state==SEND) & (idx==N*N-1)`, `busy = (state==SEND)`.
- AXIS rule: while `m_tvalid & ~m_tready`, `m_tdata` and `m_tlast` are held stable and `m_tvalid` does not drop.
- `m_tvalid` does not depend combinationally on `m_tready`.
- Throughput: one element per cycle with `m_tready` held high, so N*N cycles per set.
- A `done` level that stays high never retriggers. A new set requires `done` to fall and then rise again.

## Configuration
- `RESULT_SAT_EN` defined: signed saturation. Values above 2^(OUT_W-1)-1 output the max, and values below -2^(OUT_W-1) output the min. Otherwise the low OUT_W bits are passed.
- Not defined: plain truncation to the low OUT_W bits (wrap).
- When OUT_W == ACC_W, both modes are identity.

## Test plan
- Basic drain (N=2, ACC_W=32, OUT_W=16, `m_tready`=1): acc = {e0=5, e1=-3, e2=100, e3=7}, then pulse `done` → `m_tdata` is 5, -3, 100, 7 on four consecutive cycles starting one cycle after the rise. `m_tlast` is high only on 7. `busy` is low afterwards.
- Backpressure: same data, with `m_tready` low on cycles 1–3 and on every other cycle after → each element is held stable until accepted. Exactly 4 handshakes occur, and the order is unchanged.
- Conversion: e0=40000, e1=-40000, e2=32767, e3=-32768.
  - With `RESULT_SAT_EN`: output is 32767, -32768, 32767, -32768.
  - Without it: output is -25536, 25536, 32767, -32768.
- Overrun: a second `done` rise while idx=1 → `overrun`=1 and the stream still emits the original 4 values. Pulsing `ovr_clr` returns `overrun` to 0.
- Back-to-back: a `done` rise in the same cycle as the final handshake → the next cycle presents element 0 of the new set with `m_tvalid` continuously high, and `overrun` stays 0.
- Reset mid-stream: assert `rst_n`=0 at idx=2 → the next cycle shows `m_tvalid`=0, `busy`=0 and `overrun`=0. A subsequent `done` rise drains a full fresh 4-element set.
